// File: rtl/apb_reg_bank_param.sv
// apb_reg_bank_param
//   APB slave register bank: read-only ID, sticky W1C STATUS with masked
//   interrupt, IRQ_MASK, SYSTEM, NUM_CFG config registers and an external
//   memory window serviced by a small request/ack FSM with timeout.
// Ports
//   pclk, reset          clock, asynchronous active-high reset
//   psel..pslverr        APB slave port (word addressed)
//   status_set_i, irq_o  sticky status event inputs, registered interrupt
//   data_system_o        SYSTEM register, clr_sys_reg clears it
//   cfg_data_o           flattened config words, cfg_update_o write strobes
//   mem_*                memory window request/ack interface
module apb_reg_bank_param #(
  parameter int unsigned ADDRESS_BUS_WIDTH = 16,
  parameter int unsigned DATA_BUS_WIDTH    = 32,
  parameter int unsigned NUM_CFG           = 8,
  parameter logic [NUM_CFG*DATA_BUS_WIDTH-1:0] CFG_RESET = {NUM_CFG{32'h00C08240}},
  parameter int unsigned STATUS_WIDTH      = 8,
  parameter logic [DATA_BUS_WIDTH-1:0] ID_VALUE = 32'hEA000100,
  parameter int unsigned MEM_DEPTH         = 1024,
  parameter int unsigned TIMEOUT_CYCLES    = 16
) (
  input  logic                                pclk,
  input  logic                                reset,
  input  logic                                psel,
  input  logic                                penable,
  input  logic                                pwrite,
  input  logic [ADDRESS_BUS_WIDTH-1:0]        paddr,
  input  logic [DATA_BUS_WIDTH-1:0]           pwdata,
  output logic [DATA_BUS_WIDTH-1:0]           prdata,
  output logic                                pready,
  output logic                                pslverr,
  input  logic [STATUS_WIDTH-1:0]             status_set_i,
  output logic                                irq_o,
  output logic [DATA_BUS_WIDTH-1:0]           data_system_o,
  input  logic                                clr_sys_reg,
  output logic [NUM_CFG*DATA_BUS_WIDTH-1:0]   cfg_data_o,
  output logic [NUM_CFG-1:0]                  cfg_update_o,
  output logic                                mem_req_o,
  output logic                                mem_we_o,
  output logic [ADDRESS_BUS_WIDTH-1:0]        mem_addr_o,
  output logic [DATA_BUS_WIDTH-1:0]           mem_wdata_o,
  input  logic [DATA_BUS_WIDTH-1:0]           mem_rdata_i,
  input  logic                                mem_ack_i
);

  localparam int unsigned DW       = DATA_BUS_WIDTH;
  localparam int unsigned AW       = ADDRESS_BUS_WIDTH;
  localparam int unsigned CFG_BASE = 4;
  localparam int unsigned MEM_BASE = CFG_BASE + NUM_CFG;
  localparam int unsigned MEM_END  = MEM_BASE + MEM_DEPTH;
  localparam int unsigned CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW-1:0] MEM_BASE_A = AW'(MEM_BASE);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} mem_state_e;

  mem_state_e                 state_q;
  logic [CW-1:0]              cnt_q;
  logic [DW-1:0]              mem_rdata_q;
  logic                       mem_err_q;

  logic [STATUS_WIDTH-1:0]    status_q, status_d;
  logic [STATUS_WIDTH-1:0]    mask_q, mask_d;
  logic                       irq_q;
  logic [DW-1:0]              sys_q, sys_d;
  logic [NUM_CFG*DW-1:0]      cfg_q, cfg_d;
  logic [NUM_CFG-1:0]         upd_q, upd_d;

  logic [31:0]                addr_w;
  logic                       access;
  logic                       is_id, is_stat, is_mask, is_sys, is_mem, is_unmapped;
  logic                       reg_err, reg_acc, reg_wr;
  logic [DW-1:0]              reg_rdata;

  // Address decode
  always_comb begin
    addr_w      = 32'(paddr);
    access      = psel & penable;
    is_id       = (addr_w == 32'd0);
    is_stat     = (addr_w == 32'd1);
    is_mask     = (addr_w == 32'd2);
    is_sys      = (addr_w == 32'd3);
    is_mem      = (addr_w >= MEM_BASE) && (addr_w < MEM_END);
    is_unmapped = (addr_w >= MEM_END);
    reg_err     = is_unmapped | (is_id & pwrite);
    reg_acc     = access & ~is_mem;
    reg_wr      = reg_acc & pwrite & ~reg_err;
  end

  // Register read mux
  always_comb begin
    reg_rdata = '0;
    if (is_id)        reg_rdata = ID_VALUE;
    else if (is_stat) reg_rdata = DW'(status_q);
    else if (is_mask) reg_rdata = DW'(mask_q);
    else if (is_sys)  reg_rdata = sys_q;
    for (int unsigned i = 0; i < NUM_CFG; i++) begin
      if (addr_w == 32'(CFG_BASE + i)) reg_rdata = cfg_q[i*DW +: DW];
    end
  end

  // APB response: registers answer in the first access cycle, memory in DONE
  always_comb begin
    prdata  = '0;
    pready  = 1'b0;
    pslverr = 1'b0;
    if (reg_acc) begin
      pready  = 1'b1;
      pslverr = reg_err;
      if (!pwrite && !reg_err) prdata = reg_rdata;
    end else if (access && state_q == S_DONE) begin
      pready  = 1'b1;
      pslverr = mem_err_q;
      prdata  = mem_err_q ? '0 : mem_rdata_q;
    end
  end

  // Register next-state
  always_comb begin
    // Clear first, then OR in events so a same-cycle set survives the W1C.
    status_d = status_q;
    if (reg_wr && is_stat) status_d = status_d & ~pwdata[STATUS_WIDTH-1:0];
    status_d = status_d | status_set_i;

    mask_d = mask_q;
    if (reg_wr && is_mask) mask_d = pwdata[STATUS_WIDTH-1:0];

    sys_d = sys_q;
    if (clr_sys_reg)          sys_d = '0;
    else if (reg_wr && is_sys) sys_d = pwdata;

    cfg_d = cfg_q;
    upd_d = '0;
    for (int unsigned i = 0; i < NUM_CFG; i++) begin
      if (reg_wr && addr_w == 32'(CFG_BASE + i)) begin
        cfg_d[i*DW +: DW] = pwdata;
        upd_d[i]          = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      status_q <= '0;
      mask_q   <= '0;
      irq_q    <= 1'b0;
      sys_q    <= '0;
      cfg_q    <= CFG_RESET;
      upd_q    <= '0;
    end else begin
      status_q <= status_d;
      mask_q   <= mask_d;
      irq_q    <= |(status_q & mask_q);
      sys_q    <= sys_d;
      cfg_q    <= cfg_d;
      upd_q    <= upd_d;
    end
  end

  // Memory window FSM
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_rdata_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (access && is_mem) begin
            state_q     <= S_REQ;
            mem_req_o   <= 1'b1;
            mem_we_o    <= pwrite;
            mem_addr_o  <= paddr - MEM_BASE_A;
            mem_wdata_o <= pwdata;
            mem_rdata_q <= '0;
            mem_err_q   <= 1'b0;
          end
        end
        S_REQ: begin
          // cnt_q counts completed REQ cycles, so the last allowed one is TIMEOUT_CYCLES-1.
          if (mem_ack_i) begin
            state_q     <= S_DONE;
            mem_req_o   <= 1'b0;
            mem_rdata_q <= mem_we_o ? '0 : mem_rdata_i;
          end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_q   <= S_DONE;
            mem_req_o <= 1'b0;
            mem_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign irq_o         = irq_q;
  assign data_system_o = sys_q;
  assign cfg_data_o    = cfg_q;
  assign cfg_update_o  = upd_q;

endmodule

// File: tb/tb_apb_reg_bank_param.sv
// Directed testbench for apb_reg_bank_param with default parameters.
module tb_apb_reg_bank_param;

  logic          pclk = 1'b0;
  logic          reset;
  logic          psel, penable, pwrite;
  logic [15:0]   paddr;
  logic [31:0]   pwdata, prdata;
  logic          pready, pslverr;
  logic [7:0]    status_set_i;
  logic          irq_o;
  logic [31:0]   data_system_o;
  logic          clr_sys_reg;
  logic [255:0]  cfg_data_o;
  logic [7:0]    cfg_update_o;
  logic          mem_req_o, mem_we_o;
  logic [15:0]   mem_addr_o;
  logic [31:0]   mem_wdata_o, mem_rdata_i;
  logic          mem_ack_i;

  int n_assert = 0;
  int n_fail   = 0;

  // memory responder controls / observations
  int          ack_after = 0;
  logic [31:0] ack_data  = '0;
  int          req_cnt   = 0;
  int          last_len  = 0;
  logic        req_seen  = 1'b0;

  logic [31:0] rd;
  logic        err;
  int          cyc;

  apb_reg_bank_param #(
    .ADDRESS_BUS_WIDTH(16),
    .DATA_BUS_WIDTH(32),
    .NUM_CFG(8),
    .STATUS_WIDTH(8),
    .MEM_DEPTH(1024),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk(pclk), .reset(reset),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .status_set_i(status_set_i), .irq_o(irq_o),
    .data_system_o(data_system_o), .clr_sys_reg(clr_sys_reg),
    .cfg_data_o(cfg_data_o), .cfg_update_o(cfg_update_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic [15:0] a, input logic w, input logic [31:0] wd,
                     output logic [31:0] r, output logic e, output int c);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = wd;
    @(posedge pclk); #1;
    penable = 1'b1;
    c = 0;
    do begin
      @(negedge pclk);
      c++;
    end while (!pready && c < 64);
    r = prdata;
    e = pslverr;
    if (!pready) chk("apb_timeout", 32'(pready), 32'd1);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Memory responder: acks in the ack_after-th cycle of mem_req_o (0 = never)
  initial begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge pclk); #2;
      mem_ack_i = 1'b0;
      if (mem_req_o) begin
        req_cnt++;
        req_seen = 1'b1;
        if (ack_after != 0 && req_cnt == ack_after) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = ack_data;
        end
      end else begin
        if (req_cnt != 0) last_len = req_cnt;
        req_cnt = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; status_set_i = '0; clr_sys_reg = 1'b0;
    repeat (3) @(posedge pclk);
    #1 reset = 1'b0;

    // reset state
    chk("rst_prdata",  prdata, 32'h0);
    chk("rst_pready",  32'(pready), 32'h0);
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    chk("rst_irq",     32'(irq_o), 32'h0);
    chk("rst_system",  data_system_o, 32'h0);
    chk("rst_cfg0",    cfg_data_o[31:0], 32'h00C08240);
    chk("rst_cfg7",    cfg_data_o[255:224], 32'h00C08240);
    chk("rst_cfg_upd", 32'(cfg_update_o), 32'h0);
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    chk("rst_mem_we",  32'(mem_we_o), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr_o), 32'h0);
    chk("rst_mem_wdata", mem_wdata_o, 32'h0);

    // register reads, zero wait states
    apb(16'd0, 1'b0, 32'h0, rd, err, cyc);
    chk("rd_id", rd, 32'hEA000100); chk("rd_id_err", 32'(err), 32'h0); chk("rd_id_cyc", 32'(cyc), 32'd1);
    apb(16'd2, 1'b0, 32'h0, rd, err, cyc);
    chk("rd_mask", rd, 32'h0); chk("rd_mask_cyc", 32'(cyc), 32'd1);
    apb(16'd3, 1'b0, 32'h0, rd, err, cyc);
    chk("rd_sys", rd, 32'h0);
    apb(16'd4, 1'b0, 32'h0, rd, err, cyc);
    chk("rd_cfg0", rd, 32'h00C08240); chk("rd_cfg0_err", 32'(err), 32'h0);
    apb(16'd11, 1'b0, 32'h0, rd, err, cyc);
    chk("rd_cfg7", rd, 32'h00C08240); chk("rd_cfg7_err", 32'(err), 32'h0);

    // cfg write and update strobe
    apb(16'd5, 1'b1, 32'h12345678, rd, err, cyc);
    chk("cfg1_err", 32'(err), 32'h0);
    chk("cfg1_word", cfg_data_o[63:32], 32'h12345678);
    chk("cfg0_word", cfg_data_o[31:0], 32'h00C08240);
    chk("cfg_upd_on", 32'(cfg_update_o), 32'h02);
    @(posedge pclk); #1;
    chk("cfg_upd_off", 32'(cfg_update_o), 32'h00);
    apb(16'd5, 1'b0, 32'h0, rd, err, cyc);
    chk("cfg1_rdback", rd, 32'h12345678);

    // write to ID errors without side effect
    apb(16'd0, 1'b1, 32'hFFFFFFFF, rd, err, cyc);
    chk("wr_id_err", 32'(err), 32'h1); chk("wr_id_cyc", 32'(cyc), 32'd1);
    apb(16'd0, 1'b0, 32'h0, rd, err, cyc);
    chk("id_unchanged", rd, 32'hEA000100);

    // status / irq
    @(posedge pclk); #1 status_set_i = 8'h05;
    @(posedge pclk); #1 status_set_i = 8'h00;
    chk("irq_nomask", 32'(irq_o), 32'h0);
    apb(16'd2, 1'b1, 32'h04, rd, err, cyc);
    chk("irq_lag", 32'(irq_o), 32'h0);
    @(posedge pclk); #1;
    chk("irq_set", 32'(irq_o), 32'h1);
    apb(16'd1, 1'b0, 32'h0, rd, err, cyc);
    chk("status_05", rd, 32'h05);
    status_set_i = 8'h04;
    apb(16'd1, 1'b1, 32'h04, rd, err, cyc);
    status_set_i = 8'h00;
    apb(16'd1, 1'b0, 32'h0, rd, err, cyc);
    chk("status_set_wins", rd, 32'h05);
    apb(16'd1, 1'b1, 32'h04, rd, err, cyc);
    apb(16'd1, 1'b0, 32'h0, rd, err, cyc);
    chk("status_w1c", rd, 32'h01);
    chk("irq_cleared", 32'(irq_o), 32'h0);

    // SYSTEM with clear priority
    clr_sys_reg = 1'b1;
    apb(16'd3, 1'b1, 32'hFF, rd, err, cyc);
    clr_sys_reg = 1'b0;
    chk("sys_clr_wins", data_system_o, 32'h0);
    apb(16'd3, 1'b1, 32'hFF, rd, err, cyc);
    chk("sys_written", data_system_o, 32'hFF);
    apb(16'd3, 1'b0, 32'h0, rd, err, cyc);
    chk("sys_rdback", rd, 32'hFF);

    // memory read, ack in 3rd REQ cycle
    ack_after = 3; ack_data = 32'hCAFE0001;
    apb(16'd12, 1'b0, 32'h0, rd, err, cyc);
    chk("mem_rd_data", rd, 32'hCAFE0001); chk("mem_rd_err", 32'(err), 32'h0);
    chk("mem_rd_cyc", 32'(cyc), 32'd5);
    chk("mem_rd_addr", 32'(mem_addr_o), 32'h0); chk("mem_rd_we", 32'(mem_we_o), 32'h0);
    chk("mem_rd_len", 32'(last_len), 32'd3);

    // minimum latency at top of window
    ack_after = 1; ack_data = 32'h00000BEE;
    apb(16'd1035, 1'b0, 32'h0, rd, err, cyc);
    chk("mem_min_cyc", 32'(cyc), 32'd3); chk("mem_min_data", rd, 32'h00000BEE);
    chk("mem_top_addr", 32'(mem_addr_o), 32'd1023);

    // first unmapped address
    req_seen = 1'b0;
    apb(16'd1036, 1'b0, 32'h0, rd, err, cyc);
    chk("unmap_err", 32'(err), 32'h1); chk("unmap_cyc", 32'(cyc), 32'd1);
    chk("unmap_data", rd, 32'h0); chk("unmap_noreq", 32'(req_seen), 32'h0);

    // memory write timeout
    ack_after = 0;
    apb(16'd20, 1'b1, 32'h0000DEAD, rd, err, cyc);
    chk("tmo_err", 32'(err), 32'h1); chk("tmo_data", rd, 32'h0);
    chk("tmo_cyc", 32'(cyc), 32'd18); chk("tmo_len", 32'(last_len), 32'd16);
    chk("tmo_we", 32'(mem_we_o), 32'h1); chk("tmo_addr", 32'(mem_addr_o), 32'd8);
    chk("tmo_wdata", mem_wdata_o, 32'h0000DEAD);

    // asynchronous reset during REQ
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 16'd12; pwrite = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    chk("mid_req_high", 32'(mem_req_o), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_req", 32'(mem_req_o), 32'h0);
    chk("rst_async_pready", 32'(pready), 32'h0);
    chk("rst_async_cfg1", cfg_data_o[63:32], 32'h00C08240);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1 reset = 1'b0;
    ack_after = 1; ack_data = 32'h5A5A0003;
    apb(16'd14, 1'b0, 32'h0, rd, err, cyc);
    chk("post_rst_cyc", 32'(cyc), 32'd3); chk("post_rst_data", rd, 32'h5A5A0003);
    chk("post_rst_addr", 32'(mem_addr_o), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
